// File: rtl/uart_fifo.sv
// uart_fifo: full-duplex UART with runtime baud divisor, FWFT RX/TX FIFOs and per-word error flags; define UART_MAJORITY_VOTE_EN for 2-of-3 RX sampling.
// Latency: start bit 2 clk after a write into an idle TX path; RX word visible 1 clk after the last stop-bit sample.
// Backpressure: uart_tx_dr is TX FIFO not-full; an RX word arriving at a full FIFO is dropped and flagged on rx_overrun.

module uart_fifo_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the addresses match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push_vld && !full;
    assign do_pop   = pop_rdy && !empty;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module uart_fifo #(
    parameter int    NR_BITS    = 8,
    parameter string PARITY     = "NONE",
    parameter int    STOP_BITS  = 1,
    parameter int    DIV_WIDTH  = 16,
    parameter int    FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic [NR_BITS-1:0]   uart_tx_d,
    input  logic                 uart_tx_dv,
    output logic                 uart_tx_dr,
    output logic                 tx_busy,
    output logic [NR_BITS-1:0]   uart_rx_d,
    output logic                 uart_rx_dv,
    input  logic                 uart_rx_dr,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 rx_overrun,
    input  logic                 uart_rx,
    output logic                 uart_tx
);
    localparam bit                   PAR_EN    = (PARITY != "NONE");
    localparam bit                   PAR_ODD   = (PARITY == "ODD");
    localparam logic [4:0]           LAST_DATA = 5'(NR_BITS - 1);
    localparam logic [4:0]           LAST_STOP = 5'(STOP_BITS - 1);
    localparam logic [DIV_WIDTH-1:0] MIN_DIV   = DIV_WIDTH'(3);
    localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [DIV_WIDTH-1:0] div_clamped;
    assign div_clamped = (baud_div < MIN_DIV) ? MIN_DIV : baud_div;

    // ---------------- transmit ----------------
    logic [NR_BITS-1:0]   tx_head;
    logic                 tx_full, tx_empty, tx_pop;
    state_t               tx_state, tx_state_n;
    logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [4:0]           tx_bit, tx_bit_n;
    logic [NR_BITS-1:0]   tx_shift, tx_shift_n;
    logic                 tx_par, tx_par_n, tx_line, tx_q;

    uart_fifo_buf #(.WIDTH(NR_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (uart_tx_dv && uart_tx_dr),
        .push_dat (uart_tx_d),
        .pop_rdy  (tx_pop),
        .head_dat (tx_head),
        .full     (tx_full),
        .empty    (tx_empty)
    );

    assign uart_tx_dr = !tx_full;
    assign tx_busy    = !tx_empty || (tx_state != S_IDLE);
    assign uart_tx    = tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_div   <= MIN_DIV;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            tx_par   <= tx_par_n;
            tx_q     <= tx_line;
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + ONE;
        tx_div_n   = tx_div;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_par_n   = tx_par;
        tx_pop     = 1'b0;
        tx_line    = 1'b1;
        case (tx_state)
            S_IDLE: begin
                tx_cnt_n = '0;
                if (!tx_empty) tx_pop = 1'b1;
            end
            S_START: begin
                tx_line = 1'b0;
                if (tx_cnt == tx_div) begin
                    tx_cnt_n   = '0;
                    tx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                tx_line = tx_shift[0];
                if (tx_cnt == tx_div) begin
                    tx_cnt_n   = '0;
                    tx_shift_n = tx_shift >> 1;
                    if (tx_bit == LAST_DATA) begin
                        tx_bit_n   = '0;
                        tx_state_n = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        tx_bit_n = tx_bit + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                tx_line = tx_par;
                if (tx_cnt == tx_div) begin
                    tx_cnt_n   = '0;
                    tx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (tx_cnt == tx_div) begin
                    tx_cnt_n = '0;
                    if (tx_bit == LAST_STOP) begin
                        tx_bit_n = '0;
                        // Chain straight into the next start bit so frames abut.
                        if (!tx_empty) tx_pop = 1'b1;
                        else           tx_state_n = S_IDLE;
                    end else begin
                        tx_bit_n = tx_bit + 5'd1;
                    end
                end
            end
            default: tx_state_n = S_IDLE;
        endcase
        if (tx_pop) begin
            tx_state_n = S_START;
            tx_cnt_n   = '0;
            tx_bit_n   = '0;
            tx_div_n   = div_clamped;
            tx_shift_n = tx_head;
            tx_par_n   = PAR_ODD ? ~^tx_head : ^tx_head;
        end
    end

    // ---------------- receive ----------------
    logic                 rx_s1, rx_s2, rx_s3;
    logic                 rx_bit_val, rx_samp, rx_push;
    logic                 rx_full, rx_empty;
    logic [NR_BITS+1:0]   rx_head;
    state_t               rx_state, rx_state_n;
    logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [4:0]           rx_bit, rx_bit_n;
    logic [NR_BITS-1:0]   rx_shift, rx_shift_n;
    logic                 rx_pe, rx_pe_n, rx_fe, rx_fe_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= uart_rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

`ifdef UART_MAJORITY_VOTE_EN
    logic rx_s4;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_s4 <= 1'b1;
        else        rx_s4 <= rx_s3;
    end
    // Decide one cycle after mid so the history holds mid-1, mid and mid+1.
    assign rx_bit_val = (rx_s4 & rx_s3) | (rx_s4 & rx_s2) | (rx_s3 & rx_s2);
    assign rx_samp    = (rx_cnt == (rx_div >> 1) + ONE);
`else
    assign rx_bit_val = rx_s2;
    assign rx_samp    = (rx_cnt == (rx_div >> 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_div   <= MIN_DIV;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_pe    <= 1'b0;
            rx_fe    <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
            rx_pe    <= rx_pe_n;
            rx_fe    <= rx_fe_n;
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + ONE;
        rx_div_n   = rx_div;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        rx_pe_n    = rx_pe;
        rx_fe_n    = rx_fe;
        rx_push    = 1'b0;
        case (rx_state)
            S_IDLE: begin
                rx_cnt_n = '0;
                // Needs a high-to-low edge, so a line held low after a framing error never re-arms.
                if (rx_s3 && !rx_s2) begin
                    rx_state_n = S_START;
                    rx_div_n   = div_clamped;
                    rx_bit_n   = '0;
                    rx_pe_n    = 1'b0;
                    rx_fe_n    = 1'b0;
                end
            end
            S_START: begin
                if (rx_samp && rx_bit_val) begin
                    rx_state_n = S_IDLE;
                end else if (rx_cnt == rx_div) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_samp) rx_shift_n = {rx_bit_val, rx_shift[NR_BITS-1:1]};
                if (rx_cnt == rx_div) begin
                    rx_cnt_n = '0;
                    if (rx_bit == LAST_DATA) begin
                        rx_bit_n   = '0;
                        rx_state_n = PAR_EN ? S_PARITY : S_STOP;
                    end else begin
                        rx_bit_n = rx_bit + 5'd1;
                    end
                end
            end
            S_PARITY: begin
                if (rx_samp) rx_pe_n = rx_bit_val ^ (PAR_ODD ? ~^rx_shift : ^rx_shift);
                if (rx_cnt == rx_div) begin
                    rx_cnt_n   = '0;
                    rx_state_n = S_STOP;
                end
            end
            S_STOP: begin
                if (rx_samp) begin
                    if (!rx_bit_val) rx_fe_n = 1'b1;
                    if (rx_bit == LAST_STOP) begin
                        rx_push    = 1'b1;
                        rx_state_n = S_IDLE;
                    end
                end
                if (rx_cnt == rx_div) begin
                    rx_cnt_n = '0;
                    rx_bit_n = rx_bit + 5'd1;
                end
            end
            default: rx_state_n = S_IDLE;
        endcase
    end

    uart_fifo_buf #(.WIDTH(NR_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (rx_push),
        .push_dat ({rx_fe | ~rx_bit_val, rx_pe, rx_shift}),
        .pop_rdy  (uart_rx_dr),
        .head_dat (rx_head),
        .full     (rx_full),
        .empty    (rx_empty)
    );

    assign rx_overrun = rx_push && rx_full;
    assign uart_rx_dv = !rx_empty;
    assign uart_rx_d  = uart_rx_dv ? rx_head[NR_BITS-1:0] : '0;
    assign parity_err = uart_rx_dv && rx_head[NR_BITS];
    assign frame_err  = uart_rx_dv && rx_head[NR_BITS+1];
endmodule
